// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM states and overflow helper for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_SLTU = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_MULU = 4'hA;
    localparam logic [3:0] OP_DIVU = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Signed overflow from operand and result sign bits; subtract flips the b-sign test.
    function automatic logic signed_oflow(input logic is_sub, input logic sa,
                                          input logic sb, input logic sr);
        return (is_sub ? (sa != sb) : (sa == sb)) && (sr != sa);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between decode, seq_alu and writeback.
interface seq_alu_if #(parameter int unsigned WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rslt;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             oflow;
    logic             busy;

    modport master (
        output in_valid, control, a, b, out_ready,
        input  in_ready, out_valid, rslt, hi, zero, oflow, busy
    );

    modport slave (
        input  in_valid, control, a, b, out_ready,
        output in_ready, out_valid, rslt, hi, zero, oflow, busy
    );

endinterface

// File: rtl/seq_alu_iter.sv
// Iterative unsigned multiply (shift-add) and, with SEQ_ALU_DIV_EN, restoring divide.
// acc_c is the accumulator value after the current step; done_c flags the last step.
module seq_alu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef SEQ_ALU_DIV_EN
    input  logic               is_div,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_c,
    output logic               done_c
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned AW  = 2 * WIDTH;

    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic [SHW-1:0]   count;
    logic             run;
    logic [WIDTH:0]   mul_sum;
`ifdef SEQ_ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   cand;
    logic [WIDTH:0]   diff;
`endif

    // One datapath step: multiplier bits shift out of acc low half, partial product grows in high half.
    always_comb begin
        mul_sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        acc_c   = {mul_sum, acc[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        cand = {acc[AW-1:WIDTH], acc[WIDTH-1]};
        diff = cand - {1'b0, opnd};
        if (div_q) begin
            acc_c = diff[WIDTH] ? {cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
`endif
        done_c = run && (count == SHW'(WIDTH - 1));
    end

    // Load operands on start, then advance one step per cycle for WIDTH cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            count <= '0;
            run   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            run   <= 1'b1;
            count <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= is_div;
            acc   <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd  <= is_div ? b : a;
`else
            acc   <= {{WIDTH{1'b0}}, b};
            opnd  <= a;
`endif
        end else if (run) begin
            acc   <= acc_c;
            count <= count + SHW'(1);
            if (done_c) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-pass ops in one cycle, MULU/DIVU over WIDTH cycles.
// Define SEQ_ALU_DIV_EN to include the DIVU datapath; otherwise 0xB is an unused code.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   rslt_q, rslt_nxt, hi_q, hi_nxt;
    logic               out_valid_q, out_valid_nxt;
    logic               oflow_q, oflow_nxt;
    logic               busy_q, busy_nxt;
    logic               in_ready_q, zero_q;
    logic               start_c;
    logic               is_div_c, is_iter_c;
    logic [WIDTH-1:0]   sum_c, diff_c, sp_rslt_c;
    logic               sp_oflow_c, sub_ovf_c;
    logic [SHW-1:0]     shamt_c;
    logic [2*WIDTH-1:0] acc_c;
    logic               done_c;

`ifdef SEQ_ALU_DIV_EN
    assign is_div_c = (bus.control == OP_DIVU);
`else
    assign is_div_c = 1'b0;
`endif
    assign is_iter_c = (bus.control == OP_MULU) || is_div_c;

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
`ifdef SEQ_ALU_DIV_EN
        .is_div (is_div_c),
`endif
        .a      (bus.a),
        .b      (bus.b),
        .acc_c  (acc_c),
        .done_c (done_c)
    );

    // Single-pass results computed straight from the request operands.
    always_comb begin
        sum_c      = bus.a + bus.b;
        diff_c     = bus.a - bus.b;
        shamt_c    = bus.a[SHW-1:0];
        sub_ovf_c  = signed_oflow(1'b1, bus.a[MSB], bus.b[MSB], diff_c[MSB]);
        sp_rslt_c  = '0;
        sp_oflow_c = 1'b0;
        case (bus.control)
            OP_ADD: begin
                sp_rslt_c  = sum_c;
                sp_oflow_c = signed_oflow(1'b0, bus.a[MSB], bus.b[MSB], sum_c[MSB]);
            end
            OP_SUB: begin
                sp_rslt_c  = diff_c;
                sp_oflow_c = sub_ovf_c;
            end
            OP_SLL:  sp_rslt_c = bus.b << shamt_c;
            OP_OR:   sp_rslt_c = bus.a | bus.b;
            OP_AND:  sp_rslt_c = bus.a & bus.b;
            OP_SLTU: sp_rslt_c = WIDTH'(bus.a < bus.b);
            OP_SLT:  sp_rslt_c = WIDTH'(diff_c[MSB] ^ sub_ovf_c);
            OP_XOR:  sp_rslt_c = bus.a ^ bus.b;
            OP_SRL:  sp_rslt_c = bus.b >> shamt_c;
            OP_SRA:  sp_rslt_c = $unsigned($signed(bus.b) >>> shamt_c);
            default: sp_rslt_c = '0;
        endcase
    end

    // Next state and next output values; outputs hold unless a transition updates them.
    always_comb begin
        state_nxt     = state;
        rslt_nxt      = rslt_q;
        hi_nxt        = hi_q;
        out_valid_nxt = out_valid_q;
        oflow_nxt     = oflow_q;
        busy_nxt      = busy_q;
        start_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_iter_c) begin
                        state_nxt = ST_BUSY;
                        busy_nxt  = 1'b1;
                        start_c   = 1'b1;
                    end else begin
                        state_nxt     = ST_DONE;
                        out_valid_nxt = 1'b1;
                        rslt_nxt      = sp_rslt_c;
                        hi_nxt        = '0;
                        oflow_nxt     = sp_oflow_c;
                    end
                end
            end
            ST_BUSY: begin
                if (done_c) begin
                    state_nxt     = ST_DONE;
                    busy_nxt      = 1'b0;
                    out_valid_nxt = 1'b1;
                    rslt_nxt      = acc_c[WIDTH-1:0];
                    hi_nxt        = acc_c[2*WIDTH-1:WIDTH];
                    oflow_nxt     = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt     = ST_IDLE;
                    out_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rslt_q      <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            oflow_q     <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            zero_q      <= 1'b1;
        end else begin
            state       <= state_nxt;
            rslt_q      <= rslt_nxt;
            hi_q        <= hi_nxt;
            out_valid_q <= out_valid_nxt;
            oflow_q     <= oflow_nxt;
            busy_q      <= busy_nxt;
            in_ready_q  <= (state_nxt == ST_IDLE);
            zero_q      <= (rslt_nxt == '0);
        end
    end

    assign bus.rslt      = rslt_q;
    assign bus.hi        = hi_q;
    assign bus.out_valid = out_valid_q;
    assign bus.oflow     = oflow_q;
    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the op definitions.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] h, output logic o,
                         output int lat);
        longint s;
        longint lim;
        logic [63:0] p;
        lim = 64'sh7FFFFFFF;
        r = 32'h0; h = 32'h0; o = 1'b0; lat = 1;
        case (op)
            4'h0: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                o = (s > lim) || (s < -lim - 1);
            end
            4'h1: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                o = (s > lim) || (s < -lim - 1);
            end
            4'h2: r = b << a[4:0];
            4'h3: r = a | b;
            4'h4: r = a & b;
            4'h5: r = (a < b) ? 32'd1 : 32'd0;
            4'h6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: r = a ^ b;
            4'h8: r = b >> a[4:0];
            4'h9: r = $unsigned($signed(b) >>> a[4:0]);
            4'hA: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
                h = p[63:32];
                lat = 33;
            end
`ifdef SEQ_ALU_DIV_EN
            4'hB: begin
                if (b == 32'h0) begin
                    r = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    r = a / b;
                    h = a % b;
                end
                lat = 33;
            end
`endif
            default: ;
        endcase
    endtask

    // Present a request for one cycle, then scramble the inputs to prove they were latched.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready_before", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.control  = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.control  = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    // Wait (bounded) for out_valid and compare everything against the model.
    task automatic collect(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er, eh;
        logic eo;
        int el, lat;
        model(op, a, b, er, eh, eo, el);
        lat = 1;
        @(negedge clk);
        check("busy_early", 64'(bus.busy), 64'(el > 1));
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(el));
        check("rslt", 64'(bus.rslt), 64'(er));
        check("hi", 64'(bus.hi), 64'(eh));
        check("zero", 64'(bus.zero), 64'(er == 32'h0));
        check("oflow", 64'(bus.oflow), 64'(eo));
        check("busy_done", 64'(bus.busy), 64'(0));
        check("in_ready_done", 64'(bus.in_ready), 64'(0));
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_fall", 64'(bus.out_valid), 64'(0));
        check("in_ready_back", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        collect(op, a, b);
        release_result();
    endtask

    initial begin
        logic [31:0] ra, rb, held_r, held_h;
        logic [3:0] rop;

        bus.in_valid  = 1'b0;
        bus.control   = 4'h0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_rslt", 64'(bus.rslt), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_zero", 64'(bus.zero), 64'(1));
        check("rst_oflow", 64'(bus.oflow), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed boundary cases
        run_op(4'h0, 32'h7FFF_FFFF, 32'h1);
        run_op(4'h1, 32'h8000_0000, 32'h1);
        run_op(4'h1, 32'h5, 32'h5);
        run_op(4'h6, 32'hFFFF_FFFF, 32'h1);
        run_op(4'h5, 32'hFFFF_FFFF, 32'h1);
        run_op(4'h9, 32'h4, 32'h8000_0000);
        run_op(4'h8, 32'h24, 32'h8000_0000);
        run_op(4'h2, 32'h1F, 32'h3);
        run_op(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(4'hA, 32'h0, 32'h1234_5678);
        run_op(4'hB, 32'd100, 32'd7);
        run_op(4'hB, 32'd100, 32'd0);
        run_op(4'hF, 32'h1234, 32'h5678);

        // Backpressure: result holds and new requests are ignored while out_ready is low
        issue(4'h7, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        collect(4'h7, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        held_r = 32'hA5A5_0F0F ^ 32'h0FF0_FFFF;
        held_h = 32'h0;
        bus.in_valid = 1'b1;
        bus.control  = 4'h0;
        bus.a        = 32'h1;
        bus.b        = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_rslt", 64'(bus.rslt), 64'(held_r));
            check("bp_hi", 64'(bus.hi), 64'(held_h));
        end
        bus.in_valid = 1'b0;
        release_result();
        @(negedge clk);
        check("bp_no_queue", 64'(bus.out_valid), 64'(0));

        // Reset in the middle of a multiply
        issue(4'hA, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("mid_rst_hi", 64'(bus.hi), 64'(0));
        repeat (40) @(negedge clk);
        check("mid_rst_no_stale", 64'(bus.out_valid), 64'(0));
        run_op(4'h0, 32'd3, 32'd4);

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom_range(0, 40); rb = $urandom_range(0, 40); end
                1: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            run_op(rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the single-cycle ALU, for the multi-cycle datapath.
- Keeps the existing 4-bit op encoding (codes 0x0–0x7) as single-pass ops with registered results.
- Adds logical/arithmetic right shift, overflow reporting, and iterative unsigned multiply/divide that take WIDTH cycles.
- Sits between decode and writeback; the writeback stage stalls on the out_valid/out_ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (state IDLE).
- control  in  4  op code, sampled on accept.
- a, b  in  WIDTH  operands, sampled on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- rslt  out  WIDTH  primary result.
- hi  out  WIDTH  MULU high half / DIVU remainder; 0 for all other ops.
- zero  out  1  (rslt == 0).
- oflow  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; out_valid=0, rslt=0, hi=0, oflow=0, busy=0, in_ready=1. zero is 1 because rslt=0.
- Reset mid-operation: any in-flight or pending result is discarded.
- Accept: in_valid && in_ready at a posedge. Operands and control are latched; later changes on a/b/control are ignored.
- Op codes:
  - 0x0 ADD: a+b.
  - 0x1 SUB: a−b.
  - 0x2 SLL: b << a[SHW-1:0].
  - 0x3 OR.
  - 0x4 AND.
  - 0x5 SLTU: unsigned a<b ? 1 : 0.
  - 0x6 SLT: signed, computed as sign of (a−b) XOR sub-overflow.
  - 0x7 XOR.
  - 0x8 SRL: b >> a[SHW-1:0].
  - 0x9 SRA: b >>> a[SHW-1:0].
  - 0xA MULU: {hi,rslt} = a*b, full 2·WIDTH-bit unsigned product.
  - 0xB DIVU: rslt = a/b, hi = a%b (unsigned).
  - 0xC–0xF: rslt=0, hi=0, single-pass.
- All arithmetic wraps modulo 2^WIDTH.
- oflow for ADD: a[MSB]==b[MSB] && sum[MSB]!=a[MSB].
- oflow for SUB: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB].
- Divide by zero: rslt = all ones, hi = a, oflow=0; still takes WIDTH cycles.
- States:
  - IDLE: on accept of a single-pass op, load result and go to DONE; out_valid=1 the next cycle (latency 1). On accept of MULU/DIVU, go to BUSY, busy=1, count=0.
  - BUSY: one shift-add (MULU) or restoring-subtract (DIVU) step per cycle. After WIDTH steps go to DONE; out_valid rises WIDTH+1 cycles after accept.
  - DONE: out_valid=1, in_ready=0. Outputs hold stable until out_ready. On out_ready go to IDLE, out_valid=0 next cycle.
- No back-to-back overlap: the earliest next accept is the cycle after out_valid falls. Max throughput is one single-pass op per 2 cycles.
- out_ready while not out_valid is ignored. in_valid while !in_ready is ignored; the request is not queued.

Optional Feature:
- SEQ_ALU_DIV_EN defined: DIVU (0xB) present as above.
- Not defined: the divider datapath and remainder logic are omitted. 0xB behaves as an unused code: single-pass, rslt=0, hi=0, oflow=0. MULU is unaffected.

Decomposition:
- Package seq_alu_pkg holds:
  - op code localparams: OP_ADD..OP_DIVU, 4-bit;
  - state enum: ST_IDLE, ST_BUSY, ST_DONE;
  - helper function for signed overflow.
- One sub-module: seq_alu_iter (WIDTH-parameterised). It holds the shared iterative multiply/divide datapath, with start, is_div, done, and a 2·WIDTH accumulator.
- The top level holds the FSM, the single-pass combinational ops and the output registers.

Test Plan:
- Reset then ADD, WIDTH=32: a=0x7FFFFFFF, b=1, out_ready=1 → out_valid 1 cycle after accept; rslt=0x80000000, oflow=1, zero=0, hi=0.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 → SLT rslt=1; SLTU rslt=0. SRA a=4, b=0x80000000 → rslt=0xF8000000.
- MULU: a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 32 cycles, out_valid at accept+33; hi=0xFFFFFFFE, rslt=0x00000001.
- DIVU (with SEQ_ALU_DIV_EN): a=100, b=7 → rslt=14, hi=2. Same with b=0 → rslt=0xFFFFFFFF, hi=100. Without the macro, 0xB → rslt=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → rslt/hi/out_valid stable, in_ready=0, new in_valid ignored. Release → out_valid drops, in_ready=1 next cycle.
- Reset mid-MULU at cycle 10 → next cycle out_valid=0, busy=0, in_ready=1. A subsequent ADD 3+4 returns 7 with no stale hi.
